// File: rtl/sdram_burst_fetch.sv
// sdram_burst_fetch: turns word-count fetch requests into single SDRAM burst
// reads and buffers the returned 32-bit beats in a first-word-fall-through FIFO.
// A burst is only issued once the FIFO has room for every word it will return,
// because the SDRAM controller cannot be stalled mid-burst.
// Optional build macro: SDRAM_FETCH_TIMEOUT_EN adds a COLLECT watchdog that
// abandons a burst after TIMEOUT_CYCLES quiet clocks and raises err_timeout.
`timescale 1ns/1ps

module sdram_burst_fetch #(
    parameter int FIFO_DEPTH     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        controller_clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [25:0] req_addr,
    input  logic [9:0]  req_words,
    output logic        burst_rd,
    output logic [25:0] burst_addr,
    output logic [10:0] burst_len,
    output logic        burst_32bit,
    input  logic [31:0] burst_data,
    input  logic        burst_data_valid,
    input  logic        burst_data_done,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        err_short,
    output logic        err_overflow,
    output logic        err_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 8 || FIFO_DEPTH > 512 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 8..512");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        ISSUE,
        COLLECT
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [25:0]     addr_lat;
    logic [9:0]      words_lat;
    logic [9:0]      beat_cnt;
    logic [9:0]      cnt_after;
    logic            beat_extra;
    logic            extra_after;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occupancy;
    logic [31:0]     mem [FIFO_DEPTH];
    logic            tag_mem [FIFO_DEPTH];
    logic [10:0]     free_cnt;

    logic            accept;
    logic            req_legal;
    logic            space_ok;
    logic            beat_in;
    logic            done_in;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            push_drop;
    logic            short_done;
    logic            timeout_hit;

    assign burst_32bit = 1'b1;

    assign accept     = req_valid && req_ready;
    assign req_legal  = (req_words != 10'd0) && (11'(req_words) <= 11'(FIFO_DEPTH));
    assign free_cnt   = 11'(FIFO_DEPTH) - 11'(occupancy);
    assign space_ok   = free_cnt >= 11'(words_lat);

    // Beats and done strobes only mean something while a burst is being collected.
    assign beat_in    = (state == COLLECT) && burst_data_valid;
    assign done_in    = (state == COLLECT) && burst_data_done;

    assign fifo_full  = (occupancy == CW'(FIFO_DEPTH));
    assign fifo_empty = (occupancy == '0);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign push       = beat_in && (!fifo_full || pop);
    assign push_drop  = beat_in && fifo_full && !pop;

    assign out_data   = out_valid ? mem[rd_ptr] : 32'd0;
    assign out_last   = out_valid && tag_mem[rd_ptr];

    // Beat accounting after this cycle's beat, so a beat arriving with done is counted first.
    always_comb begin
        cnt_after   = beat_cnt;
        extra_after = beat_extra;
        if (beat_in) begin
            if (beat_cnt != 10'd0) begin
                cnt_after = beat_cnt - 10'd1;
            end else begin
                extra_after = 1'b1;
            end
        end
    end

    assign short_done = done_in && ((cnt_after != 10'd0) || extra_after);

`ifdef SDRAM_FETCH_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign timeout_hit = (state == COLLECT) && !burst_data_done && !burst_data_valid
                         && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts quiet COLLECT cycles, restarted on entry and by every beat.
    always_ff @(posedge controller_clk) begin
        if (!reset_n) begin
            tmo_cnt     <= 32'd0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ISSUE || beat_in) begin
                tmo_cnt <= 32'd0;
            end else if (state == COLLECT) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state decode plus the state-derived handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept && req_legal) begin
                    state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = COLLECT;
            end
            COLLECT: begin
                if (done_in || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, request latch, burst command registers and sticky error flags.
    always_ff @(posedge controller_clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            burst_rd     <= 1'b0;
            burst_addr   <= 26'd0;
            burst_len    <= 11'd0;
            addr_lat     <= 26'd0;
            words_lat    <= 10'd0;
            beat_cnt     <= 10'd0;
            beat_extra   <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            burst_rd <= (state_nxt == ISSUE);
            if (accept) begin
                addr_lat  <= req_addr;
                words_lat <= req_words;
            end
            if (state == WAIT_SPACE && space_ok) begin
                burst_addr <= addr_lat;
                burst_len  <= {words_lat, 1'b0};
            end
            if (state == ISSUE) begin
                beat_cnt   <= words_lat;
                beat_extra <= 1'b0;
            end else if (beat_in) begin
                beat_cnt   <= cnt_after;
                beat_extra <= extra_after;
            end
            if ((accept && !req_legal) || short_done) begin
                err_short <= 1'b1;
            end
            if (push_drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge controller_clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // FIFO storage: data word plus its end-of-request tag.
    always_ff @(posedge controller_clk) begin
        if (reset_n && push) begin
            mem[wr_ptr]     <= burst_data;
            tag_mem[wr_ptr] <= (beat_cnt == 10'd1);
        end
    end

endmodule

// File: tb/tb_sdram_burst_fetch.sv
// Directed bench for sdram_burst_fetch: stimulus queues expected FIFO words,
// a negedge monitor pops and compares whenever the DUT hands a word out.
`timescale 1ns/1ps

module tb_sdram_burst_fetch;

    localparam int DEPTH = 64;

    logic        controller_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [25:0] req_addr = '0;
    logic [9:0]  req_words = '0;
    logic        burst_rd;
    logic [25:0] burst_addr;
    logic [10:0] burst_len;
    logic        burst_32bit;
    logic [31:0] burst_data = '0;
    logic        burst_data_valid = 1'b0;
    logic        burst_data_done = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        err_short;
    logic        err_overflow;
    logic        err_timeout;

    always #5 controller_clk = ~controller_clk;

    sdram_burst_fetch #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .controller_clk   (controller_clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_words        (req_words),
        .burst_rd         (burst_rd),
        .burst_addr       (burst_addr),
        .burst_len        (burst_len),
        .burst_32bit      (burst_32bit),
        .burst_data       (burst_data),
        .burst_data_valid (burst_data_valid),
        .burst_data_done  (burst_data_done),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .err_short        (err_short),
        .err_overflow     (err_overflow),
        .err_timeout      (err_timeout)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   pops_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every word the consumer takes must match the head of the expected queue.
    exp_t mon_e;
    always @(negedge controller_clk) begin
        if (reset_n && out_valid && out_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no word", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_last", 32'(out_last), 32'(mon_e.last));
            end
        end
    end

    task automatic tick();
        @(posedge controller_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":req_ready"},    32'(req_ready),    32'd1);
        check({tag, ":busy"},         32'(busy),         32'd0);
        check({tag, ":burst_rd"},     32'(burst_rd),     32'd0);
        check({tag, ":out_valid"},    32'(out_valid),    32'd0);
        check({tag, ":err_short"},    32'(err_short),    32'd0);
        check({tag, ":err_overflow"}, 32'(err_overflow), 32'd0);
        check({tag, ":err_timeout"},  32'(err_timeout),  32'd0);
        check({tag, ":burst_addr"},   32'(burst_addr),   32'd0);
        check({tag, ":burst_len"},    32'(burst_len),    32'd0);
        check({tag, ":out_data"},     out_data,          32'd0);
        check({tag, ":burst_32bit"},  32'(burst_32bit),  32'd1);
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        req_valid        = 1'b0;
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    // Presents a request and returns one cycle after the accepting edge.
    task automatic request(input logic [25:0] a, input logic [9:0] w);
        int k;
        req_valid = 1'b1;
        req_addr  = a;
        req_words = w;
        for (k = 0; k < 200; k++) begin
            if (req_ready) break;
            tick();
        end
        check("req_ready_seen", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Returns in the cycle burst_rd is high.
    task automatic wait_burst(input string name);
        int k;
        for (k = 0; k < 32; k++) begin
            if (burst_rd) break;
            tick();
        end
        check({name, ":burst_seen"}, 32'(burst_rd), 32'd1);
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic store, input logic with_done);
        burst_data_valid = 1'b1;
        burst_data       = d;
        burst_data_done  = with_done;
        if (store) exp_q.push_back('{data: d, last: last});
        tick();
        burst_data_valid = 1'b0;
        burst_data_done  = 1'b0;
    endtask

    task automatic done_only();
        burst_data_done = 1'b1;
        tick();
        burst_data_done = 1'b0;
    endtask

    task automatic drain(input string name, input int start, input int expect_pops);
        int k;
        out_ready = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (!out_valid) break;
            tick();
        end
        out_ready = 1'b0;
        check({name, ":pops"},    32'(pops_seen - start), 32'(expect_pops));
        check({name, ":q_empty"}, 32'(exp_q.size()),      32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int rd_count;

        // Reset state, sampled while reset is still asserted.
        tick();
        tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();

        // Basic fetch: 4 words, burst_rd exactly at N+2, last beat coincides with done.
        out_ready = 1'b1;
        p = pops_seen;
        request(26'h0000100, 10'd4);
        check("basic:rd_n1",     32'(burst_rd),  32'd0);
        check("basic:busy",      32'(busy),      32'd1);
        check("basic:req_ready", 32'(req_ready), 32'd0);
        tick();
        check("basic:rd_n2", 32'(burst_rd),   32'd1);
        check("basic:addr",  32'(burst_addr), 32'h100);
        check("basic:len",   32'(burst_len),  32'd8);
        tick();
        check("basic:rd_pulse", 32'(burst_rd), 32'd0);
        for (int i = 0; i < 3; i++) beat(32'hA000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
        beat(32'hA000_0003, 1'b1, 1'b1, 1'b1);
        check("basic:busy_after", 32'(busy),      32'd0);
        check("basic:err_short",  32'(err_short), 32'd0);
        drain("basic", p, 4);

        // Space gating: 62 words held, 4-word request waits until 2 pops free room.
        out_ready = 1'b0;
        request(26'h0000000, 10'd62);
        wait_burst("fill");
        tick();
        for (int i = 0; i < 62; i++) beat(32'h0000_1000 + 32'(i), (i == 61), 1'b1, 1'b0);
        done_only();
        request(26'h0000200, 10'd4);
        rd_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (burst_rd) rd_count++;
            tick();
        end
        check("gate:no_burst", 32'(rd_count), 32'd0);
        check("gate:busy",     32'(busy),     32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        wait_burst("gate");
        check("gate:addr", 32'(burst_addr), 32'h200);
        check("gate:len",  32'(burst_len),  32'd8);
        tick();
        for (int i = 0; i < 4; i++) beat(32'h0000_2000 + 32'(i), (i == 3), 1'b1, 1'b0);
        // FIFO now full: an extra beat with a pop is stored, one without is dropped.
        out_ready = 1'b1;
        beat(32'h0000_2004, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("full_pop:err_overflow", 32'(err_overflow), 32'd0);
        beat(32'h0000_2005, 1'b0, 1'b0, 1'b0);
        check("full_drop:err_overflow", 32'(err_overflow), 32'd1);
        done_only();
        check("extra:err_short", 32'(err_short), 32'd1);
        check("extra:busy",      32'(busy),      32'd0);
        p = pops_seen;
        drain("full", p, 64);

        // Short burst: 8 requested, 5 delivered.
        do_reset();
        check_idle("reset2");
        out_ready = 1'b0;
        request(26'h0000400, 10'd8);
        wait_burst("short");
        tick();
        for (int i = 0; i < 5; i++) beat(32'h0000_4000 + 32'(i), 1'b0, 1'b1, 1'b0);
        done_only();
        check("short:err_short", 32'(err_short), 32'd1);
        check("short:req_ready", 32'(req_ready), 32'd1);
        check("short:out_valid", 32'(out_valid), 32'd1);
        p = pops_seen;
        drain("short", p, 5);

        // Reset after beat 2 of 8; the remaining beats must be ignored.
        do_reset();
        out_ready = 1'b0;
        request(26'h0000500, 10'd8);
        wait_burst("midrst");
        check("midrst:addr", 32'(burst_addr), 32'h500);
        tick();
        beat(32'h0000_5000, 1'b0, 1'b0, 1'b0);
        beat(32'h0000_5001, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        beat(32'h0000_5002, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 3; i < 8; i++) beat(32'h0000_5000 + 32'(i), 1'b0, 1'b0, (i == 7));
        check_idle("midrst");
        p = pops_seen;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("midrst:pops", 32'(pops_seen - p), 32'd0);

        // Illegal word counts are accepted and discarded.
        request(26'h0000600, 10'd0);
        check("zero:busy",      32'(busy),      32'd0);
        check("zero:req_ready", 32'(req_ready), 32'd1);
        check("zero:err_short", 32'(err_short), 32'd1);
        do_reset();
        request(26'h0000600, 10'd65);
        check("big:busy",      32'(busy),      32'd0);
        check("big:err_short", 32'(err_short), 32'd1);
        tick();
        check("big:burst_rd",  32'(burst_rd),  32'd0);
        do_reset();

        // No beats after the burst command.
        request(26'h0000700, 10'd2);
        wait_burst("tmo");
        tick();
`ifdef SDRAM_FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("tmo:busy_before", 32'(busy),        32'd1);
        check("tmo:err_before",  32'(err_timeout), 32'd0);
        tick();
        check("tmo:err_timeout", 32'(err_timeout), 32'd1);
        check("tmo:req_ready",   32'(req_ready),   32'd1);
`else
        for (int i = 0; i < 40; i++) tick();
        check("notmo:busy",        32'(busy),        32'd1);
        check("notmo:err_timeout", 32'(err_timeout), 32'd0);
        check("notmo:req_ready",   32'(req_ready),   32'd0);
        done_only();
        check("notmo:busy_after",  32'(busy),        32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_burst_fetch.md
SDRAM_BURST_FETCH -- requirements
Module: sdram_burst_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 64, is the number of 32-bit entries in the output FIFO; it SHALL be a power of two, 8..512.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, is the watchdog limit in clocks (see REQ-022).
REQ-003 Ports SHALL be as follows; one clock; reset is synchronous and active-low.
- controller_clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are high.
- req_addr  in  26  byte address.
- req_words  in  10  number of 32-bit words; legal range 1..FIFO_DEPTH.
- burst_rd  out  1  one-cycle burst start pulse to the SDRAM controller.
- burst_addr  out  26  byte address of the burst.
- burst_len  out  11  length in 16-bit SDRAM reads.
- burst_32bit  out  1  32-bit packing select; tied to 1.
- burst_data  in  32  read data from the controller.
- burst_data_valid  in  1  burst_data qualifier.
- burst_data_done  in  1  end of burst.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pop.
- out_last  out  1  head word is the final word of its request.
- busy  out  1  high whenever state is not IDLE.
- err_short  out  1  sticky: done arrived with beat count not equal to req_words.
- err_overflow  out  1  sticky: beat arrived while the FIFO was full.
- err_timeout  out  1  sticky watchdog flag.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, WAIT_SPACE, ISSUE, COLLECT.
REQ-005 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-006 Acceptance of a request SHALL latch addr and words and move IDLE->WAIT_SPACE.
REQ-007 A request with req_words=0 or req_words>FIFO_DEPTH SHALL be accepted and then discarded: stay in IDLE, issue no burst, set err_short.
REQ-008 WAIT_SPACE->ISSUE SHALL occur when free entries (FIFO_DEPTH minus occupancy) >= latched words, so the unstallable controller can never overrun the FIFO.
REQ-009 In ISSUE, burst_rd SHALL be registered high for exactly one cycle, together with burst_addr=latched addr and burst_len=2*words. The FSM then moves to COLLECT.
REQ-010 Minimum latency from acceptance at cycle N to burst_rd high SHALL be cycle N+2.
REQ-011 In COLLECT, each burst_data_valid SHALL push burst_data and decrement a beat counter. The push carries a last tag when the counter reaches 1.
REQ-012 burst_data_done in COLLECT SHALL return the FSM to IDLE. If the beat counter is not 0 at that point, err_short SHALL be set.
REQ-013 A burst_data_valid and burst_data_done in the same cycle SHALL push the beat first, then evaluate the count.
REQ-014 burst_data_valid or burst_data_done seen outside COLLECT SHALL be ignored with no FIFO write.
REQ-015 The FIFO SHALL be first-word-fall-through: a word pushed at cycle M gives out_valid=1 at M+1.
REQ-016 out_last SHALL equal the head entry's tag, qualified by out_valid.
REQ-017 Pop SHALL occur when out_valid and out_ready are both high.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 A push while full SHALL be dropped and set err_overflow; a pop while empty SHALL have no effect.
REQ-020 A new request MAY be accepted while the FIFO still holds the previous request's words.

Reset
REQ-021 When reset_n is sampled low, all of the following SHALL apply on the next edge, including mid-burst:
- state=IDLE.
- FIFO pointers and occupancy cleared.
- burst_rd, out_valid, busy, and all err_* flags = 0.
- req_ready=1.
- burst_addr, burst_len, and out_data = 0.
- burst_32bit=1.
Beats still arriving after reset SHALL be ignored per REQ-014.

Configuration
REQ-022 When macro SDRAM_FETCH_TIMEOUT_EN is defined, a counter SHALL clear on entry to COLLECT and on every beat. Reaching TIMEOUT_CYCLES SHALL force IDLE and set err_timeout; FIFO contents are kept.
REQ-023 When SDRAM_FETCH_TIMEOUT_EN is undefined, no counter SHALL exist, err_timeout SHALL be tied 0, and COLLECT SHALL wait indefinitely for done.

Verification
REQ-024 Basic fetch: req_addr=0x0000100, req_words=4, out_ready=1, controller model returns 4 beats then done -> one burst_rd pulse with burst_len=8 at N+2; 4 words out; out_last only on the 4th; busy falls after done.
REQ-025 Space gating: FIFO_DEPTH=64 holding 62 words with out_ready=0, then request req_words=4 -> no burst_rd; after 2 pops, burst_rd fires.
REQ-026 Short burst: req_words=8, model returns 5 beats then done -> err_short=1, 5 words in FIFO, FSM in IDLE.
REQ-027 Full-with-pop: FIFO full and beat pushed simultaneously with pop -> occupancy stays 64, no err_overflow.
REQ-028 Reset mid-burst: reset_n low after beat 2 of 8, remaining beats then arrive -> FIFO empty, out_valid=0, all flags 0.
REQ-029 Timeout (macro defined, TIMEOUT_CYCLES=16): no beats after burst_rd -> err_timeout=1 after 16 cycles and req_ready=1; with macro undefined, busy stays 1.
